// File: rtl/fft_pkg.sv
// Shared types, twiddle table and index helpers for the streaming radix-2 FFT.
package fft_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

  // The table is stored at 10-bit precision (1.0 == 256); wider TW_W shifts it up.
  localparam int TW_BASE_W = 10;
  localparam int TW_PTS    = 16;

  // cos(2*pi*i/16) * 256, rounded to nearest.
  localparam logic signed [TW_BASE_W-1:0] TW_COS [TW_PTS] = '{
    10'sd256,  10'sd237,  10'sd181,  10'sd98,
    10'sd0,   -10'sd98,  -10'sd181, -10'sd237,
   -10'sd256, -10'sd237, -10'sd181, -10'sd98,
    10'sd0,    10'sd98,   10'sd181,  10'sd237
  };

  // sin(2*pi*i/16) * 256; the twiddle is W = cos - j*sin.
  localparam logic signed [TW_BASE_W-1:0] TW_SIN [TW_PTS] = '{
    10'sd0,    10'sd98,   10'sd181,  10'sd237,
    10'sd256,  10'sd237,  10'sd181,  10'sd98,
    10'sd0,   -10'sd98,  -10'sd181, -10'sd237,
   -10'sd256, -10'sd237, -10'sd181, -10'sd98
  };

  // Reverse the low 'bits' bits of v (bits <= 4); upper result bits stay zero.
  function automatic logic [3:0] bitrev(input logic [3:0] v, input int bits);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < bits) r[2'(bits - 1 - i)] = v[2'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly.sv
// Combinational complex radix-2 butterfly: t = W*b, a' = a+t, b' = a-t.
// Twiddles 1 and -j bypass the multiplier so they stay exact.
module fft_bfly
  import fft_pkg::*;
#(
  parameter int OUT_W = 10,
  parameter int TW_W  = 10
) (
  input  logic signed [OUT_W-1:0] a_re,
  input  logic signed [OUT_W-1:0] a_im,
  input  logic signed [OUT_W-1:0] b_re,
  input  logic signed [OUT_W-1:0] b_im,
  input  logic signed [TW_W-1:0]  w_re,
  input  logic signed [TW_W-1:0]  w_im,
  output logic signed [OUT_W-1:0] ap_re,
  output logic signed [OUT_W-1:0] ap_im,
  output logic signed [OUT_W-1:0] bp_re,
  output logic signed [OUT_W-1:0] bp_im
);

  // Two full products plus one bit for their sum never overflow.
  localparam int P_W = OUT_W + TW_W + 1;
  localparam logic signed [TW_W-1:0] ONE = TW_W'(1) <<< (TW_W - 2);
  localparam logic signed [P_W-1:0]  RND = P_W'(1) <<< (TW_W - 3);

  logic signed [P_W-1:0]   prod_re, prod_im;
  logic signed [OUT_W-1:0] t_re, t_im;

  // Twiddle product with round-half-up, then the add/subtract pair.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else can leave a value held and infer a latch.
    prod_re = P_W'(b_re) * P_W'(w_re) - P_W'(b_im) * P_W'(w_im) + RND;
    prod_im = P_W'(b_re) * P_W'(w_im) + P_W'(b_im) * P_W'(w_re) + RND;
    t_re    = OUT_W'(prod_re >>> (TW_W - 2));
    t_im    = OUT_W'(prod_im >>> (TW_W - 2));
    if (w_re == ONE && w_im == '0) begin
      t_re = b_re;
      t_im = b_im;
    end else if (w_re == '0 && w_im == -ONE) begin
      // -j * (br + j*bi) = bi - j*br
      t_re = b_im;
      t_im = -b_re;
    end
    ap_re = a_re + t_re;
    ap_im = a_im + t_im;
    bp_re = a_re - t_re;
    bp_im = a_im - t_im;
  end

endmodule

// File: rtl/fft_stream_r2.sv
// Serial-in/serial-out radix-2 DIT FFT: samples are loaded in bit-reversed
// order, one shared butterfly transforms the buffer in place, then bins are
// read out one per readyin rising edge. TW_W must be at least 10.
module fft_stream_r2
  import fft_pkg::*;
#(
  parameter int NPT    = 4,
  parameter int DATA_W = 8,
  parameter int TW_W   = 10,
  localparam int LOG2N = $clog2(NPT),
  localparam int OUT_W = DATA_W + LOG2N
) (
  input  logic                    fastclock,
  input  logic                    rst,
  input  logic                    readyin,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [OUT_W-1:0] y_re,
  output logic signed [OUT_W-1:0] y_im,
  output logic [LOG2N-1:0]        k,
  output logic                    validout,
  output logic                    busy,
  output logic                    err
);

  localparam int S_W = $clog2(LOG2N);
  localparam logic [LOG2N-1:0] N_LAST = LOG2N'(NPT - 1);
  localparam logic [LOG2N-1:0] J_LAST = LOG2N'(NPT / 2 - 1);
  localparam logic [S_W-1:0]   S_LAST = S_W'(LOG2N - 1);

  state_t                  state;
  logic                    readyin_q;
  logic                    rise;
  logic [LOG2N-1:0]        n, j;
  logic [S_W-1:0]          s;
  logic signed [OUT_W-1:0] mem_re [NPT];
  logic signed [OUT_W-1:0] mem_im [NPT];

  logic [LOG2N-1:0]        wr_idx, half_mask, pos, a_idx, b_idx;
  logic [3:0]              tw_idx;
  logic signed [TW_W-1:0]  w_re, w_im;
  logic signed [OUT_W-1:0] ap_re, ap_im, bp_re, bp_im;

  assign rise = readyin & ~readyin_q;

  // Butterfly addressing for stage s, butterfly j, plus the load address.
  always_comb begin
    wr_idx    = LOG2N'(bitrev(4'(n), LOG2N));
    half_mask = (LOG2N'(1) << s) - LOG2N'(1);
    pos       = j & half_mask;
    a_idx     = (((j >> s) << s) << 1) | pos;
    b_idx     = a_idx | (LOG2N'(1) << s);
    // pos * NPT/2^(s+1) in NPT terms is pos * 8/2^s in 16-point table terms.
    tw_idx    = 4'((8'(pos) << 3) >> s);
    w_re      = TW_W'(TW_COS[tw_idx]) <<< (TW_W - TW_BASE_W);
    w_im      = -(TW_W'(TW_SIN[tw_idx]) <<< (TW_W - TW_BASE_W));
  end

  fft_bfly #(
    .OUT_W (OUT_W),
    .TW_W  (TW_W)
  ) u_bfly (
    .a_re  (mem_re[a_idx]),
    .a_im  (mem_im[a_idx]),
    .b_re  (mem_re[b_idx]),
    .b_im  (mem_im[b_idx]),
    .w_re  (w_re),
    .w_im  (w_im),
    .ap_re (ap_re),
    .ap_im (ap_im),
    .bp_re (bp_re),
    .bp_im (bp_im)
  );

  // Control FSM, counters, sample buffer and registered outputs.
  always_ff @(posedge fastclock or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      readyin_q <= 1'b1;   // readyin held high through reset is not an edge
      n         <= '0;
      j         <= '0;
      s         <= '0;
      k         <= '0;
      y_re      <= '0;
      y_im      <= '0;
      validout  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      // NOTE: the buffer is a register array that must read zero after reset,
      // so it is reset here; that rules out mapping it onto a RAM macro.
      mem_re    <= '{default: '0};
      mem_im    <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments throughout, so every read in this
      // block sees the pre-edge value regardless of statement order.
      readyin_q <= readyin;
      validout  <= 1'b0;
      unique case (state)
        LOAD: begin
          if (rise) begin
            mem_re[wr_idx] <= OUT_W'(x);
            mem_im[wr_idx] <= '0;
            if (n == N_LAST) begin
              n     <= '0;
              state <= COMPUTE;
              busy  <= 1'b1;
            end else begin
              n <= n + LOG2N'(1);
            end
          end
        end
        COMPUTE: begin
          if (rise) err <= 1'b1;
          mem_re[a_idx] <= ap_re;
          mem_im[a_idx] <= ap_im;
          mem_re[b_idx] <= bp_re;
          mem_im[b_idx] <= bp_im;
          if (j == J_LAST) begin
            j <= '0;
            if (s == S_LAST) begin
              // The final butterfly touches NPT/2-1 and NPT-1, never bin 0,
              // so mem[0] already holds its final value here.
              s        <= '0;
              state    <= UNLOAD;
              busy     <= 1'b0;
              k        <= '0;
              y_re     <= mem_re[0];
              y_im     <= mem_im[0];
              validout <= 1'b1;
            end else begin
              s <= s + S_W'(1);
            end
          end else begin
            j <= j + LOG2N'(1);
          end
        end
        UNLOAD: begin
          if (rise) begin
            if (k == N_LAST) begin
              state <= LOAD;
            end else begin
              k        <= k + LOG2N'(1);
              y_re     <= mem_re[k + LOG2N'(1)];
              y_im     <= mem_im[k + LOG2N'(1)];
              validout <= 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stream_r2.sv
// Directed bench for fft_stream_r2 with a 4-point and an 8-point instance.
module tb_fft_stream_r2;

  logic fastclock = 1'b0;
  logic rst;
  logic rdy4, rdy8;
  logic signed [7:0]  x4, x8;
  logic signed [9:0]  yr4, yi4;
  logic [1:0]         k4;
  logic               v4, b4, e4;
  logic signed [10:0] yr8, yi8;
  logic [2:0]         k8;
  logic               v8, b8, e8;

  always #5 fastclock = ~fastclock;

  fft_stream_r2 #(.NPT(4), .DATA_W(8), .TW_W(10)) dut4 (
    .fastclock (fastclock), .rst (rst), .readyin (rdy4), .x (x4),
    .y_re (yr4), .y_im (yi4), .k (k4), .validout (v4), .busy (b4), .err (e4)
  );

  fft_stream_r2 #(.NPT(8), .DATA_W(8), .TW_W(10)) dut8 (
    .fastclock (fastclock), .rst (rst), .readyin (rdy8), .x (x8),
    .y_re (yr8), .y_im (yi8), .k (k8), .validout (v8), .busy (b8), .err (e8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Output capture: every validout pulse is logged, busy cycles counted.
  logic signed [31:0] cap_re [2][64];
  logic signed [31:0] cap_im [2][64];
  logic signed [31:0] cap_k  [2][64];
  int vcnt [2] = '{0, 0};
  int bcnt [2] = '{0, 0};

  always @(negedge fastclock) begin
    if (v4 && vcnt[0] < 64) begin
      cap_re[0][vcnt[0]] = yr4;
      cap_im[0][vcnt[0]] = yi4;
      cap_k[0][vcnt[0]]  = {30'd0, k4};
      vcnt[0]++;
    end
    if (v8 && vcnt[1] < 64) begin
      cap_re[1][vcnt[1]] = yr8;
      cap_im[1][vcnt[1]] = yi8;
      cap_k[1][vcnt[1]]  = {29'd0, k8};
      vcnt[1]++;
    end
    if (b4) bcnt[0]++;
    if (b8) bcnt[1]++;
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One strobe: readyin high for 'hold' cycles carrying val, then low one cycle.
  task automatic strobe(input int sel, input int val, input int hold);
    if (sel == 0) begin rdy4 = 1'b1; x4 = 8'(val); end
    else          begin rdy8 = 1'b1; x8 = 8'(val); end
    repeat (hold) @(negedge fastclock);
    if (sel == 0) rdy4 = 1'b0; else rdy8 = 1'b0;
    @(negedge fastclock);
  endtask

  task automatic wait_valid(input int sel, input int target, input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge fastclock);
      #1;
      if (vcnt[sel] >= target) break;
    end
    check(tag, vcnt[sel], target);
  endtask

  int sx [8];
  int er [8];
  int ei [8];

  // Load npt samples from sx, optionally strobe once mid-COMPUTE, read all
  // bins, return to LOAD, then compare against er/ei.
  task automatic run(input string name, input int sel, input int npt,
                     input int hold, input int exp_busy, input bit inject);
    int base, bbase;
    base  = vcnt[sel];
    bbase = bcnt[sel];
    for (int i = 0; i < npt; i++) strobe(sel, sx[i], hold);
    if (inject) strobe(sel, 99, 1);
    wait_valid(sel, base + 1, {name, " bin0 pulse"});
    for (int i = 1; i < npt; i++) begin
      strobe(sel, 0, 2);
      wait_valid(sel, base + i + 1, $sformatf("%s bin%0d pulse", name, i));
    end
    strobe(sel, 0, 2);
    repeat (2) @(negedge fastclock);
    check({name, " busy cycles"}, bcnt[sel] - bbase, exp_busy);
    check({name, " pulse count"}, vcnt[sel] - base, npt);
    for (int i = 0; i < npt; i++) begin
      check($sformatf("%s bin%0d re", name, i), cap_re[sel][base + i], er[i]);
      check($sformatf("%s bin%0d im", name, i), cap_im[sel][base + i], ei[i]);
      check($sformatf("%s bin%0d k", name, i), cap_k[sel][base + i], i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rdy4 = 1'b0; rdy8 = 1'b0; x4 = '0; x8 = '0;
    repeat (3) @(negedge fastclock);
    check("rst y_re", yr4, 0);
    check("rst y_im", yi4, 0);
    check("rst k", k4, 0);
    check("rst validout", v4, 0);
    check("rst busy", b4, 0);
    check("rst err", e4, 0);
    check("rst err8", e8, 0);
    rst = 1'b0;
    repeat (2) @(negedge fastclock);

    // 4-point reference vector.
    sx = '{5, 20, 1, 30, 0, 0, 0, 0};
    er = '{56, 4, -44, 4, 0, 0, 0, 0};
    ei = '{0, 10, 0, -10, 0, 0, 0, 0};
    run("t1", 0, 4, 2, 4, 1'b0);
    check("t1 err", e4, 0);
    check("t1 k held", k4, 3);
    check("t1 y_re held", yr4, 4);
    check("t1 y_im held", yi4, -10);

    // Most negative input everywhere, readyin held long: bin0 at the range limit.
    sx = '{-128, -128, -128, -128, 0, 0, 0, 0};
    er = '{-512, 0, 0, 0, 0, 0, 0, 0};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    run("t4", 0, 4, 6, 4, 1'b0);

    // 8-point impulse: flat spectrum.
    sx = '{1, 0, 0, 0, 0, 0, 0, 0};
    er = '{1, 1, 1, 1, 1, 1, 1, 1};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    run("t2", 1, 8, 3, 12, 1'b0);
    check("t2 err", e8, 0);

    // 8-point alternating input with a strobe dropped mid-COMPUTE.
    sx = '{4, -4, 4, -4, 4, -4, 4, -4};
    er = '{0, 0, 0, 0, 32, 0, 0, 0};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    run("t3", 1, 8, 2, 12, 1'b1);
    check("t5 err sticky", e8, 1);
    repeat (5) @(negedge fastclock);
    check("t5 err still set", e8, 1);
    check("t5 err other dut", e4, 0);

    // Reset in the middle of COMPUTE, with readyin held high across it.
    for (int i = 0; i < 4; i++) strobe(0, 9, 2);
    check("t6 busy before rst", b4, 1);
    rdy4 = 1'b1;
    rst  = 1'b1;
    @(negedge fastclock);
    check("t6 rst busy", b4, 0);
    check("t6 rst k", k4, 0);
    check("t6 rst y_re", yr4, 0);
    check("t6 rst err8", e8, 0);
    rst = 1'b0;
    repeat (3) @(negedge fastclock);
    rdy4 = 1'b0;
    repeat (2) @(negedge fastclock);
    sx = '{1, 2, 3, 4, 0, 0, 0, 0};
    er = '{10, -2, -2, -2, 0, 0, 0, 0};
    ei = '{0, 2, 0, -2, 0, 0, 0, 0};
    run("t6", 0, 4, 2, 4, 1'b0);
    check("t6 err", e4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
